// File: rtl/npu_adc_readout_packer_if.sv
// ADC strobe/data pair plus buffer read port of the readout packer.
interface npu_adc_readout_packer_if #(
  parameter int ADC_BITS   = 6,
  parameter int DATA_WIDTH = 32,
  parameter int PTR_W      = 6
);
  logic                  CLKADC;
  logic [ADC_BITS-1:0]   DOUT;
  logic                  rd_en;
  logic [PTR_W-1:0]      rd_addr;
  logic [DATA_WIDTH-1:0] rd_data;

  modport master (
    output CLKADC, DOUT, rd_en, rd_addr,
    input  rd_data
  );

  modport slave (
    input  CLKADC, DOUT, rd_en, rd_addr,
    output rd_data
  );
endinterface

// File: rtl/npu_adc_readout_packer.sv
// Captures 6-bit ADC conversions on CLKADC falling edges, packs four per
// 32-bit word into a local buffer and serves registered reads from it.
// rst_n keeps its legacy name but is active-high and synchronous.
module npu_adc_readout_packer #(
  parameter int DATA_WIDTH = 32,
  parameter int ADC_BITS   = 6,
  parameter int BUF_DEPTH  = 64,
  parameter int PTR_W      = $clog2(BUF_DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     frame_start,
  input  logic                     frame_flush,
  input  logic                     capture_en,
  npu_adc_readout_packer_if.slave  bus,
  output logic [PTR_W:0]           word_count,
  output logic [15:0]              sample_count,
  output logic                     overflow,
  output logic                     frame_done
);

  localparam int LANE_W = DATA_WIDTH / 4;

  logic                    clkadc_q;
  logic [ADC_BITS-1:0]     dout_q;
  logic [1:0]              lane;
  logic [1:0]              lane_nxt;
  logic [3*LANE_W-1:0]     pack_reg;
  logic [3*LANE_W-1:0]     pack_nxt;
  logic [LANE_W-1:0]       sample_lane;
  logic                    ev;
  logic                    commit;
  logic                    commit_ok;
  logic                    full;
  logic [DATA_WIDTH-1:0]   word;
  logic [DATA_WIDTH-1:0]   mem [BUF_DEPTH];

  assign ev          = clkadc_q & ~bus.CLKADC & capture_en;
  assign sample_lane = LANE_W'(dout_q);
  assign full        = (word_count == (PTR_W+1)'(BUF_DEPTH));
  assign commit_ok   = commit & ~full & ~rst_n & ~frame_start;

  // Pack the sample first, then let a flush act on the post-sample state;
  // a sample that completes lane 3 leaves lane_nxt at 0 so a same-cycle
  // flush cannot commit a second word.
  always_comb begin
    lane_nxt = lane;
    pack_nxt = pack_reg;
    commit   = 1'b0;
    word     = '0;
    if (ev) begin
      if (lane == 2'd3) begin
        commit   = 1'b1;
        word     = DATA_WIDTH'({sample_lane, pack_reg});
        lane_nxt = 2'd0;
        pack_nxt = '0;
      end else begin
        pack_nxt[LANE_W*int'(lane) +: LANE_W] = sample_lane;
        lane_nxt = lane + 2'd1;
      end
    end
    if (frame_flush && (lane_nxt != 2'd0)) begin
      commit   = 1'b1;
      word     = DATA_WIDTH'(pack_nxt);
      lane_nxt = 2'd0;
      pack_nxt = '0;
    end
  end

  // Strobe edge detector and data delay, independent of frame control.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      clkadc_q <= 1'b0;
      dout_q   <= '0;
    end else begin
      clkadc_q <= bus.CLKADC;
      dout_q   <= bus.DOUT;
    end
  end

  // Packing state, counters and frame status.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      lane         <= 2'd0;
      pack_reg     <= '0;
      word_count   <= '0;
      sample_count <= '0;
      overflow     <= 1'b0;
      frame_done   <= 1'b0;
    end else if (frame_start) begin
      // pack_reg is cleared with lane so a later partial flush zero-fills unused lanes.
      lane         <= 2'd0;
      pack_reg     <= '0;
      word_count   <= '0;
      sample_count <= '0;
      overflow     <= 1'b0;
      frame_done   <= 1'b0;
    end else begin
      lane       <= lane_nxt;
      pack_reg   <= pack_nxt;
      frame_done <= frame_flush;
      if (ev && (sample_count != 16'hFFFF))
        sample_count <= sample_count + 16'd1;
      if (commit) begin
        if (!full) word_count <= word_count + (PTR_W+1)'(1);
        else       overflow   <= 1'b1;
      end
    end
  end

  // Buffer write port; contents survive reset and frame_start.
  always_ff @(posedge clk) begin
    if (commit_ok)
      mem[word_count[PTR_W-1:0]] <= word;
  end

  // Registered read port; same-address write in the same cycle returns old data.
  always_ff @(posedge clk) begin
    if (rst_n)
      bus.rd_data <= '0;
    else if (bus.rd_en)
      bus.rd_data <= mem[bus.rd_addr];
  end

endmodule
